date_calendar: RTL and testbench
================================

# date_calendar

Parametrised calendar-date block for the clock/alarm display design: it keeps day, month and year in BCD, advances on a day-carry pulse from the time-of-day counter, and lets the user page and edit the date with the shared button pulses. It adds a configurable year width, Gregorian leap-year handling, day clamping after edits and blinking of the field being edited. It runs entirely on the system clock with enable strobes, with no derived clocks.

## Interface
- YEAR_DIGITS, 4: year width in BCD digits, 2 or 4.
- RESET_YEAR, 2024: decimal year loaded on reset, taken modulo 10^YEAR_DIGITS.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick_en  in  1  one-cycle strobe, nominally 1 Hz; paces hold-to-increment and blinking.
- day_carry  in  1  one-cycle pulse at midnight from the time-of-day block.
- active  in  1  high when the mode selector gives this block the buttons.
- stop  in  1  freezes normal date advance.
- b0long, b0short, b1short  in  1 each  one-cycle button event pulses.
- b1long  in  1  level, high while button 1 is held long.
- cnt3, cnt2, cnt1, cnt0  out  4 each  display digits, left to right; 4'hF means blank.
- setting  out  1  edit mode active.
- field  out  2  field being edited: 0 = day, 1 = month, 2 = year.
- show  out  1  display page: 0 = MM DD, 1 = year.
- leap  out  1  the current year is a leap year.

## Operation
- **Button gating.** All button inputs are treated as 0 while active = 0.
  - Falling active forces setting and field to 0.
  - show is held when active falls.
- **Reset.** The block resets to day 01, month 01, year RESET_YEAR, setting 0, field 0, show 0, blink phase 0.
- **Month length.** max_day is 31 for months 1, 3, 5, 7, 8, 10 and 12, and 30 for months 4, 6, 9 and 11.
  - February is 29 when leap = 1 and 28 otherwise.
- **Leap rule on the low two year digits Y.**
  - Y mod 4 = 0 when the tens digit is even and the ones digit is 0, 4 or 8.
  - Y mod 4 = 0 when the tens digit is odd and the ones digit is 2 or 6.
  - YEAR_DIGITS = 4: if Y = 00, apply the same test to the high two digits (the 100/400 rule). Otherwise leap = (Y mod 4 = 0).
  - YEAR_DIGITS = 2: leap = (Y mod 4 = 0), with 00 counted as leap.
- **Normal advance.** When setting = 0, stop = 0 and day_carry = 1:
  - If day < max_day, day increments.
  - Otherwise day becomes 01 and month increments.
  - Month 12 wraps to 01 and increments the year.
  - The all-9s year wraps to all-0s.
  - day_carry is ignored, not queued, while stop = 1 or setting = 1.
- **Edit toggle.** b0long toggles setting. Entering or leaving setting clears field and the blink phase.
- **b1short.**
  - With setting = 1: field steps 0 → 1 → 2 → 0.
  - With setting = 0: show toggles.
  - With setting = 1, show is forced to 0.
- **Hold-to-increment.** With setting = 1 and b1long = 1, each tick_en increments the selected field.
  - Day wraps max_day → 01.
  - Month wraps 12 → 01.
  - Year wraps all-9s → all-0s.
  - Editing never carries into another field.
- **Clamp.** If day > max_day after any month or year change, day is set to max_day on the next clk.
- **Blink.** With setting = 1, the blink phase toggles on each tick_en.
  - While the phase is 1, the two digits of the selected field show 4'hF.
  - For the year field with YEAR_DIGITS = 4, all four digits show 4'hF.
- **Display.**
  - MM DD page (setting = 0 with show = 0, or setting = 1 with field = 0 or 1): cnt3..cnt0 = month tens, month ones, day tens, day ones.
  - Year page (setting = 0 with show = 1, or setting = 1 with field = 2): the year digits, right-aligned. cnt3 and cnt2 are F when YEAR_DIGITS = 2.
- **Priority, same cycle.**
  - b0long beats b1short, which is dropped.
  - b1short and a tick_en increment both apply. The increment targets the old field.
- b0short is reserved and has no effect.

## Timing
- All state registers update on the rising clk edge of the cycle in which the pulse or strobe is high. New values are visible the next cycle.
- cnt*, leap and max_day are combinational from the registers: zero added latency.
- Clamping takes one extra cycle after the month or year change.
- rst takes effect immediately, including in the middle of an edit.

## Test plan
- Reset with YEAR_DIGITS = 4 and RESET_YEAR = 2024 → cnt = 0,1,0,1; leap = 1. Pulse b1short → cnt = 2,0,2,4.
- Set 2023-02-28, pulse day_carry → 03-01. Set 2024-02-28, pulse day_carry twice → 02-29, then 03-01.
- Leap check: 1900 → leap = 0, 2000 → leap = 1, 2100 → leap = 0. Set 9999-12-31, pulse day_carry → 0000-01-01.
- Edit: set day 31, month 01. b0long, b1short (field = 1), hold b1long for 1 tick → month 02 and day clamps to 29 (2024) one cycle later.
- Pulse b0long and b1short in the same cycle → setting = 1, field = 0. With stop = 1, day_carry has no effect. Drop active mid-edit → setting = 0.
- YEAR_DIGITS = 2, year page → cnt3 = cnt2 = F. While editing the day, 2 tick_en strobes → day digits alternate between F and the value.

Source files
------------

// File: rtl/date_calendar_if.sv
// Button/strobe inputs and display outputs of the calendar-date block.
//   master : the mode controller / buttons side (drives strobes, reads display)
//   slave  : date_calendar itself
// Handshake semantics: there is no valid/ready pair here. Every input is a
// one-cycle pulse sampled on the rising clk edge, except active, stop and
// b1long, which are levels. Outputs are combinational from the block's
// registers and valid every cycle.
interface date_calendar_if;
  logic       tick_en;
  logic       day_carry;
  logic       active;
  logic       stop;
  logic       b0long;
  logic       b0short;
  logic       b1short;
  logic       b1long;
  logic [3:0] cnt3;
  logic [3:0] cnt2;
  logic [3:0] cnt1;
  logic [3:0] cnt0;
  logic       setting;
  logic [1:0] field;
  logic       show;
  logic       leap;

  modport master (
    output tick_en, day_carry, active, stop, b0long, b0short, b1short, b1long,
    input  cnt3, cnt2, cnt1, cnt0, setting, field, show, leap
  );

  modport slave (
    input  tick_en, day_carry, active, stop, b0long, b0short, b1short, b1long,
    output cnt3, cnt2, cnt1, cnt0, setting, field, show, leap
  );
endinterface

// File: rtl/date_calendar.sv
// Calendar date (day, month, year in BCD) for the clock/alarm display.
// Advances on day_carry, pages between MM DD and year, and supports editing
// with hold-to-increment, day clamping and blinking of the edited field.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - date_calendar_if.slave: strobes/buttons in, display digits and
//          status (setting, field, show, leap) out. setting/field expose the
//          edit state machine directly.
module date_calendar #(
  parameter int YEAR_DIGITS = 4,
  parameter int RESET_YEAR  = 2024
) (
  input logic           clk,
  input logic           rst,
  date_calendar_if.slave bus
);
  localparam int YW = 4 * YEAR_DIGITS;

  localparam logic [1:0] FIELD_DAY   = 2'd0;
  localparam logic [1:0] FIELD_MONTH = 2'd1;
  localparam logic [1:0] FIELD_YEAR  = 2'd2;

  // Decimal to BCD; keeping only YEAR_DIGITS digits gives the modulo.
  function automatic logic [YW-1:0] to_bcd(input int v);
    logic [YW-1:0] r;
    int            x;
    r = '0;
    x = v;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  localparam logic [YW-1:0] RESET_YEAR_BCD = to_bcd(RESET_YEAR);

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Ripple BCD increment; all-9s wraps to all-0s naturally.
  function automatic logic [YW-1:0] year_inc(input logic [YW-1:0] y);
    logic [YW-1:0] r;
    logic          c;
    r = y;
    c = 1'b1;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Divisibility by 4 of a two-digit BCD number: tens parity decides which
  // ones digits qualify (even tens: 0/4/8, odd tens: 2/6).
  function automatic logic bcd_mod4(input logic [7:0] v);
    if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
  endfunction

  logic [7:0]    day_q, day_d;
  logic [7:0]    month_q, month_d;
  logic [YW-1:0] year_q, year_d;
  logic          setting_q, setting_d;
  logic [1:0]    field_q, field_d;
  logic          show_q, show_d;
  logic          blink_q, blink_d;

  logic [15:0] year_pad;
  logic        leap;
  logic [7:0]  max_day;
  logic        b0long_g, b1short_g, b1long_g;
  logic        advance, edit_inc, day_written;
  logic        year_page, blank;
  logic [15:0] disp;
  logic        unused_b0short;

  // b0short is reserved for future use.
  assign unused_b0short = bus.b0short;

  assign b0long_g  = bus.active & bus.b0long;
  assign b1short_g = bus.active & bus.b1short;
  assign b1long_g  = bus.active & bus.b1long;

  assign year_pad = 16'(year_q);
  // Year 00 of a century falls back to the century digits (100/400 rule).
  assign leap = (YEAR_DIGITS == 4 && year_pad[7:0] == 8'h00) ?
                bcd_mod4(year_pad[15:8]) : bcd_mod4(year_pad[7:0]);

  always_comb begin
    case (month_q)
      8'h02:                      max_day = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: max_day = 8'h30;
      default:                    max_day = 8'h31;
    endcase
  end

  assign advance  = !setting_q && !bus.stop && bus.day_carry;
  assign edit_inc = setting_q && b1long_g && bus.tick_en;

  always_comb begin
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    setting_d   = setting_q;
    field_d     = field_q;
    show_d      = show_q;
    blink_d     = blink_q;
    day_written = 1'b0;

    // BCD compares are numeric for valid BCD; ">=" also rolls a day that is
    // still waiting to be clamped.
    if (advance) begin
      day_written = 1'b1;
      if (day_q >= max_day) begin
        day_d = 8'h01;
        if (month_q == 8'h12) begin
          month_d = 8'h01;
          year_d  = year_inc(year_q);
        end else begin
          month_d = bcd2_inc(month_q);
        end
      end else begin
        day_d = bcd2_inc(day_q);
      end
    end else if (edit_inc) begin
      case (field_q)
        FIELD_DAY: begin
          day_written = 1'b1;
          day_d = (day_q >= max_day) ? 8'h01 : bcd2_inc(day_q);
        end
        FIELD_MONTH: month_d = (month_q == 8'h12) ? 8'h01 : bcd2_inc(month_q);
        FIELD_YEAR:  year_d  = year_inc(year_q);
        default: ;
      endcase
    end

    // A month/year change can leave the day past the month end; pull it
    // back one cycle later unless the day itself is being rewritten.
    if (!day_written && day_q > max_day) day_d = max_day;

    if (b0long_g) begin
      setting_d = !setting_q;
      field_d   = FIELD_DAY;
      blink_d   = 1'b0;
    end else begin
      if (b1short_g && setting_q)
        field_d = (field_q == FIELD_YEAR) ? FIELD_DAY : field_q + 2'd1;
      if (setting_q && bus.tick_en) blink_d = !blink_q;
    end

    if (setting_q) show_d = 1'b0;
    else if (b1short_g && !b0long_g) show_d = !show_q;

    if (!bus.active) begin
      setting_d = 1'b0;
      field_d   = FIELD_DAY;
      blink_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      day_q     <= 8'h01;
      month_q   <= 8'h01;
      year_q    <= RESET_YEAR_BCD;
      setting_q <= 1'b0;
      field_q   <= FIELD_DAY;
      show_q    <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      day_q     <= day_d;
      month_q   <= month_d;
      year_q    <= year_d;
      setting_q <= setting_d;
      field_q   <= field_d;
      show_q    <= show_d;
      blink_q   <= blink_d;
    end
  end

  assign year_page = setting_q ? (field_q == FIELD_YEAR) : show_q;
  assign blank     = setting_q && blink_q;

  always_comb begin
    if (year_page) begin
      disp = (YEAR_DIGITS == 4) ? year_pad : {8'hFF, year_pad[7:0]};
      if (blank) disp = 16'hFFFF;
    end else begin
      disp = {month_q, day_q};
      if (blank) begin
        if (field_q == FIELD_DAY) disp[7:0]  = 8'hFF;
        else                      disp[15:8] = 8'hFF;
      end
    end
  end

  assign bus.cnt3    = disp[15:12];
  assign bus.cnt2    = disp[11:8];
  assign bus.cnt1    = disp[7:4];
  assign bus.cnt0    = disp[3:0];
  assign bus.setting = setting_q;
  assign bus.field   = field_q;
  assign bus.show    = show_q;
  assign bus.leap    = leap;
endmodule

// File: tb/tb_date_calendar.sv
module tb_date_calendar;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  date_calendar_if main_if ();
  date_calendar_if two_if ();

  date_calendar #(.YEAR_DIGITS(4), .RESET_YEAR(2024)) u_main (
    .clk(clk), .rst(rst), .bus(main_if.slave));
  date_calendar #(.YEAR_DIGITS(2), .RESET_YEAR(2024)) u_two (
    .clk(clk), .rst(rst), .bus(two_if.slave));

  assign two_if.tick_en   = main_if.tick_en;
  assign two_if.day_carry = main_if.day_carry;
  assign two_if.active    = main_if.active;
  assign two_if.stop      = main_if.stop;
  assign two_if.b0long    = main_if.b0long;
  assign two_if.b0short   = main_if.b0short;
  assign two_if.b1short   = main_if.b1short;
  assign two_if.b1long    = main_if.b1long;

  localparam int AUX_N = 6;
  localparam int AUX_YEARS [AUX_N] = '{1900, 2000, 2100, 2023, 2024, 9999};
  logic        aux_carry, aux_b1s;
  logic [15:0] aux_cnt  [AUX_N];
  logic [3:0]  aux_ctl  [AUX_N];
  logic        aux_leap [AUX_N];

  for (genvar g = 0; g < AUX_N; g++) begin : g_aux
    date_calendar_if aif ();
    assign aif.tick_en   = 1'b0;
    assign aif.day_carry = aux_carry;
    assign aif.active    = 1'b1;
    assign aif.stop      = 1'b0;
    assign aif.b0long    = 1'b0;
    assign aif.b0short   = 1'b0;
    assign aif.b1short   = aux_b1s;
    assign aif.b1long    = 1'b0;
    date_calendar #(.YEAR_DIGITS(4), .RESET_YEAR(AUX_YEARS[g])) u_aux (
      .clk(clk), .rst(rst), .bus(aif.slave));
    assign aux_cnt[g]  = {aif.cnt3, aif.cnt2, aif.cnt1, aif.cnt0};
    assign aux_ctl[g]  = {aif.setting, aif.field, aif.show};
    assign aux_leap[g] = aif.leap;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [20:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] obs(input int i);
    if (i == 0)
      return {main_if.cnt3, main_if.cnt2, main_if.cnt1, main_if.cnt0,
              main_if.setting, main_if.field, main_if.show, main_if.leap};
    return {two_if.cnt3, two_if.cnt2, two_if.cnt1, two_if.cnt0,
            two_if.setting, two_if.field, two_if.show, two_if.leap};
  endfunction

  // ---------------- reference model (calendar arithmetic) ----------------
  function automatic bit leap_of(input int y, input int yd);
    if (yd == 4) return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    return (y % 4 == 0);
  endfunction

  function automatic int days_in(input int m, input int y, input int yd);
    case (m)
      2:            return leap_of(y, yd) ? 29 : 28;
      4, 6, 9, 11:  return 30;
      default:      return 31;
    endcase
  endfunction

  // Returns {year[15:0], month[7:0], day[7:0]} of the following calendar day.
  function automatic logic [31:0] next_day(input int d, input int m, input int y, input int yd);
    int ymod;
    ymod = (yd == 4) ? 10000 : 100;
    if (d >= days_in(m, y, yd)) begin
      d = 1;
      if (m == 12) begin m = 1; y = (y + 1) % ymod; end
      else m = m + 1;
    end else d = d + 1;
    return {16'(y), 8'(m), 8'(d)};
  endfunction

  function automatic logic [15:0] dec4(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] md(input int m, input int d);
    return {4'(m / 10), 4'(m % 10), 4'(d / 10), 4'(d % 10)};
  endfunction

  int m_day [2];
  int m_mon [2];
  int m_year[2];
  bit m_set, m_show, m_blink;
  int m_field;

  function automatic logic [20:0] model_obs(input int i);
    logic [15:0] r;
    logic [15:0] y;
    bit yp, blank;
    yp    = m_set ? (m_field == 2) : m_show;
    blank = m_set && m_blink;
    if (yp) begin
      y = dec4(m_year[i]);
      r = (i == 0) ? y : {8'hFF, y[7:0]};
      if (blank) r = 16'hFFFF;
    end else begin
      r = md(m_mon[i], m_day[i]);
      if (blank) begin
        if (m_field == 0) r[7:0] = 8'hFF;
        else              r[15:8] = 8'hFF;
      end
    end
    return {r, m_set, 2'(m_field), m_show, leap_of(m_year[i], (i == 0) ? 4 : 2)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_day[i] = 1; m_mon[i] = 1;
      m_year[i] = (i == 0) ? 2024 : 24;
    end
    m_set = 0; m_show = 0; m_blink = 0; m_field = 0;
  endtask

  task automatic model_step(input logic [7:0] v);
    bit act, stop, carry, g0l, g1s, g1l, tick, wrote;
    bit n_set, n_show, n_blink;
    int n_field, mx, yd;
    logic [31:0] nd;
    act = v[7]; stop = v[6]; carry = v[5]; tick = v[0];
    g0l = act & v[4]; g1s = act & v[2]; g1l = act & v[1];
    for (int i = 0; i < 2; i++) begin
      yd = (i == 0) ? 4 : 2;
      mx = days_in(m_mon[i], m_year[i], yd);
      wrote = 0;
      if (!m_set && !stop && carry) begin
        nd = next_day(m_day[i], m_mon[i], m_year[i], yd);
        m_year[i] = int'(nd[31:16]); m_mon[i] = int'(nd[15:8]); m_day[i] = int'(nd[7:0]);
        wrote = 1;
      end else if (m_set && g1l && tick) begin
        if (m_field == 0) begin
          m_day[i] = (m_day[i] >= mx) ? 1 : m_day[i] + 1;
          wrote = 1;
        end else if (m_field == 1) begin
          m_mon[i] = (m_mon[i] == 12) ? 1 : m_mon[i] + 1;
        end else begin
          m_year[i] = (m_year[i] + 1) % ((yd == 4) ? 10000 : 100);
        end
      end
      if (!wrote && m_day[i] > mx) m_day[i] = mx;
    end
    n_set = m_set; n_field = m_field; n_show = m_show; n_blink = m_blink;
    if (g0l) begin
      n_set = !m_set; n_field = 0; n_blink = 0;
    end else begin
      if (g1s && m_set) n_field = (m_field + 1) % 3;
      if (m_set && tick) n_blink = !m_blink;
    end
    if (m_set) n_show = 0;
    else if (g1s && !g0l) n_show = !m_show;
    if (!act) begin n_set = 0; n_field = 0; n_blink = 0; end
    m_set = n_set; m_field = n_field; m_show = n_show; m_blink = n_blink;
    exp_q.push_back(model_obs(0));
    exp_q.push_back(model_obs(1));
  endtask

  // ---------------- driver ----------------
  // v = {active, stop, day_carry, b0long, b0short, b1short, b1long, tick_en}
  task automatic drive(input logic [7:0] v);
    main_if.active    = v[7];
    main_if.stop      = v[6];
    main_if.day_carry = v[5];
    main_if.b0long    = v[4];
    main_if.b0short   = v[3];
    main_if.b1short   = v[2];
    main_if.b1long    = v[1];
    main_if.tick_en   = v[0];
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0]  ins;
    int          reps;
    logic [15:0] cnt_main;
    logic [15:0] cnt_two;
    logic [4:0]  ctl;      // {setting, field, show, leap}
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [7:0] ins, input int reps, input logic [15:0] cm,
                     input logic [15:0] ct, input logic [4:0] ctl);
    vec_t v;
    v.ins = ins; v.reps = reps; v.cnt_main = cm; v.cnt_two = ct; v.ctl = ctl;
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] nd;
    logic [7:0]  r;
    logic [20:0] e;
    int ad[AUX_N];
    int am[AUX_N];
    int ay[AUX_N];

    add(8'b1000_0100,  1, 16'h2024, 16'hFF24, 5'b0_00_1_1); // page to year
    add(8'b1000_0100,  1, 16'h0101, 16'h0101, 5'b0_00_0_1); // back to MM DD
    add(8'b1010_0000, 30, 16'h0131, 16'h0131, 5'b0_00_0_1); // 30 day carries
    add(8'b1001_0100,  1, 16'h0131, 16'h0131, 5'b1_00_0_1); // b0long beats b1short
    add(8'b1000_0100,  1, 16'h0131, 16'h0131, 5'b1_01_0_1); // field -> month
    add(8'b1000_0011,  1, 16'hFF31, 16'hFF31, 5'b1_01_0_1); // month 02, blink on
    add(8'b1000_0000,  1, 16'hFF29, 16'hFF29, 5'b1_01_0_1); // clamp one cycle later
    add(8'b1000_0001,  1, 16'h0229, 16'h0229, 5'b1_01_0_1); // blink off
    add(8'b1001_0000,  1, 16'h0229, 16'h0229, 5'b0_00_0_1); // leave setting
    add(8'b1110_0000,  1, 16'h0229, 16'h0229, 5'b0_00_0_1); // stop blocks carry
    add(8'b1010_0000,  1, 16'h0301, 16'h0301, 5'b0_00_0_1); // 02-29 -> 03-01
    add(8'b1001_0000,  1, 16'h0301, 16'h0301, 5'b1_00_0_1); // enter setting
    add(8'b1000_0100,  2, 16'h2024, 16'hFF24, 5'b1_10_0_1); // field -> year
    add(8'b1000_0001,  1, 16'hFFFF, 16'hFFFF, 5'b1_10_0_1); // year blinks
    add(8'b1000_0011,  1, 16'h2025, 16'hFF25, 5'b1_10_0_0); // year increment
    add(8'b1000_0111,  1, 16'h03FF, 16'h03FF, 5'b1_00_0_0); // inc old field + step
    add(8'b1000_0001,  1, 16'h0301, 16'h0301, 5'b1_00_0_0); // day blink alternates
    add(8'b1000_0001,  1, 16'h03FF, 16'h03FF, 5'b1_00_0_0);
    add(8'b0000_0000,  1, 16'h0301, 16'h0301, 5'b0_00_0_0); // active drop ends edit
    add(8'b1000_0100,  1, 16'h2026, 16'hFF26, 5'b0_00_1_0); // year page
    add(8'b0000_0100,  1, 16'h2026, 16'hFF26, 5'b0_00_1_0); // gated, show held
    add(8'b1000_1000,  1, 16'h2026, 16'hFF26, 5'b0_00_1_0); // b0short ignored

    rst = 1'b0;
    aux_carry = 1'b0;
    aux_b1s   = 1'b0;
    drive(8'b1000_0000);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step_clk();

    // reset state
    check("reset_main", 32'(obs(0)), {16'h0101, 5'b0_00_0_1});
    check("reset_two",  32'(obs(1)), {16'h0101, 5'b0_00_0_1});
    for (int g = 0; g < AUX_N; g++)
      check("aux_leap_reset", 32'(aux_leap[g]), 32'(leap_of(AUX_YEARS[g], 4)));

    // table-driven directed vectors
    foreach (vq[k]) begin
      drive(vq[k].ins);
      for (int n = 0; n < vq[k].reps; n++) step_clk();
      check($sformatf("vec%0d_cnt_main", k), 32'({main_if.cnt3, main_if.cnt2, main_if.cnt1, main_if.cnt0}), 32'(vq[k].cnt_main));
      check($sformatf("vec%0d_cnt_two", k),  32'({two_if.cnt3, two_if.cnt2, two_if.cnt1, two_if.cnt0}), 32'(vq[k].cnt_two));
      check($sformatf("vec%0d_ctl_main", k), 32'(obs(0) & 21'h1F), 32'(vq[k].ctl));
      check($sformatf("vec%0d_ctl_two", k),  32'(obs(1) & 21'h1F), 32'(vq[k].ctl));
    end
    drive(8'b1000_0000);

    // month-end / leap / year-wrap walk on the fixed-year instances
    for (int g = 0; g < AUX_N; g++) begin
      ad[g] = 1; am[g] = 1; ay[g] = AUX_YEARS[g];
    end
    aux_carry = 1'b1;
    for (int n = 1; n <= 365; n++) begin
      step_clk();
      for (int g = 0; g < AUX_N; g++) begin
        nd = next_day(ad[g], am[g], ay[g], 4);
        ay[g] = int'(nd[31:16]); am[g] = int'(nd[15:8]); ad[g] = int'(nd[7:0]);
        if (n == 58 || n == 59 || n == 60 || n == 364 || n == 365)
          check($sformatf("aux%0d_day%0d", AUX_YEARS[g], n), 32'(aux_cnt[g]), 32'(md(am[g], ad[g])));
      end
    end
    aux_carry = 1'b0;
    aux_b1s   = 1'b1;
    step_clk();
    aux_b1s   = 1'b0;
    for (int g = 0; g < AUX_N; g++) begin
      check($sformatf("aux%0d_year", AUX_YEARS[g]), 32'(aux_cnt[g]), 32'(dec4(ay[g])));
      check($sformatf("aux%0d_ctl", AUX_YEARS[g]), 32'(aux_ctl[g]), 32'(4'b0_00_1));
    end

    // asynchronous reset in the middle of an edit
    drive(8'b1001_0000);
    step_clk();
    drive(8'b1000_0000);
    check("edit_entered", 32'(main_if.setting), 32'(1'b1));
    @(negedge clk) rst = 1'b0;
    #1;
    check("async_reset", 32'(obs(0)), {16'h0101, 5'b0_00_0_1});
    @(negedge clk) rst = 1'b1;

    // randomized run against the model
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      r[7] = ($urandom_range(0, 19) != 0);
      r[6] = ($urandom_range(0, 7) == 0);
      r[5] = ($urandom_range(0, 2) == 0);
      r[4] = ($urandom_range(0, 24) == 0);
      r[3] = ($urandom_range(0, 7) == 0);
      r[2] = ($urandom_range(0, 5) == 0);
      r[1] = 1'($urandom_range(0, 1));
      r[0] = ($urandom_range(0, 2) == 0);
      drive(r);
      step_clk();
      model_step(r);
      e = exp_q.pop_front();
      check("rand_main", 32'(obs(0)), 32'(e));
      e = exp_q.pop_front();
      check("rand_two", 32'(obs(1)), 32'(e));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
